// File: rtl/machine_w_core.sv
// Accumulator machine core: fetch/decode/execute FSM driving an external
// single-port memory over a req/ack handshake, with run and single-step modes.
module machine_w_core #(
  parameter int WORD_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 5,
  parameter int RESET_PC      = 0
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     start,
  input  logic                     step,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0]    mem_wdata,
  input  logic [WORD_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ack,
  output logic                     halted,
  output logic                     illegal,
  output logic [ADDRESS_WIDTH-1:0] L,
  output logic [WORD_WIDTH-1:0]    I,
  output logic [WORD_WIDTH-1:0]    Acc,
  output logic                     flag_z,
  output logic                     flag_n
);

  localparam int OPW = WORD_WIDTH - ADDRESS_WIDTH;

  localparam logic [OPW-1:0] OP_STP = OPW'(0);
  localparam logic [OPW-1:0] OP_DOD = OPW'(1);
  localparam logic [OPW-1:0] OP_ODE = OPW'(2);
  localparam logic [OPW-1:0] OP_POB = OPW'(3);
  localparam logic [OPW-1:0] OP_LAD = OPW'(4);
  localparam logic [OPW-1:0] OP_SOB = OPW'(5);
  localparam logic [OPW-1:0] OP_SOM = OPW'(6);
  localparam logic [OPW-1:0] OP_SOZ = OPW'(7);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_OPER   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] l_q, l_d;
  logic [WORD_WIDTH-1:0]    i_q, i_d;
  logic [WORD_WIDTH-1:0]    acc_q, acc_d;
  logic                     illegal_q, illegal_d;
  logic                     step_q, step_d;

  logic [OPW-1:0]           op_s;
  logic [ADDRESS_WIDTH-1:0] arg_s;
  state_t                   after_s;

  assign op_s    = i_q[WORD_WIDTH-1:ADDRESS_WIDTH];
  assign arg_s   = i_q[ADDRESS_WIDTH-1:0];
  // A single-stepped instruction returns to IDLE instead of fetching the next one.
  assign after_s = step_q ? S_IDLE : S_FETCH;

  assign flag_z  = (acc_q == {WORD_WIDTH{1'b0}});
  assign flag_n  = acc_q[WORD_WIDTH-1];
  assign L       = l_q;
  assign I       = i_q;
  assign Acc     = acc_q;
  assign illegal = illegal_q;

  // State and datapath registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      l_q       <= ADDRESS_WIDTH'(RESET_PC);
      i_q       <= {WORD_WIDTH{1'b0}};
      acc_q     <= {WORD_WIDTH{1'b0}};
      illegal_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      l_q       <= l_d;
      i_q       <= i_d;
      acc_q     <= acc_d;
      illegal_q <= illegal_d;
      step_q    <= step_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    l_d       = l_q;
    i_d       = i_q;
    acc_d     = acc_q;
    illegal_d = illegal_q;
    step_d    = step_q;
    case (state_q)
      S_IDLE: begin
        if (step) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
        end else if (start) begin
          state_d = S_FETCH;
          step_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          i_d     = mem_rdata;
          l_d     = l_q + ADDRESS_WIDTH'(1);
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (op_s)
          OP_STP: begin
            state_d = S_IDLE;
            step_d  = 1'b0;
          end
          OP_DOD, OP_ODE, OP_POB, OP_LAD: state_d = S_OPER;
          OP_SOB: begin
            l_d     = arg_s;
            state_d = after_s;
            step_d  = 1'b0;
          end
          OP_SOM: begin
            l_d     = flag_n ? arg_s : l_q;
            state_d = after_s;
            step_d  = 1'b0;
          end
          OP_SOZ: begin
            l_d     = flag_z ? arg_s : l_q;
            state_d = after_s;
            step_d  = 1'b0;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_IDLE;
            step_d    = 1'b0;
          end
        endcase
      end
      S_OPER: begin
        if (mem_ack) begin
          case (op_s)
            OP_DOD:  acc_d = acc_q + mem_rdata;
            OP_ODE:  acc_d = acc_q - mem_rdata;
            OP_POB:  acc_d = mem_rdata;
            default: acc_d = acc_q;
          endcase
          state_d = after_s;
          step_d  = 1'b0;
        end else begin
          state_d = S_OPER;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory request decode from the registered state, so it holds steady until ack.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = l_q;
    mem_wdata = acc_q;
    halted    = 1'b0;
    case (state_q)
      S_IDLE:   halted = 1'b1;
      S_FETCH:  mem_req = 1'b1;
      S_OPER: begin
        mem_req  = 1'b1;
        mem_we   = (op_s == OP_LAD);
        mem_addr = arg_s;
      end
      default:  halted = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_machine_w_core.sv
// Scoreboard bench for machine_w_core: expected memory transactions are queued
// by the stimulus and checked by a monitor at each completed handshake.
module tb_machine_w_core;

  logic       CLK, nRST, start, step;
  logic       mem_req, mem_we, mem_ack;
  logic [4:0] mem_addr, L;
  logic [7:0] mem_wdata, mem_rdata, I, Acc;
  logic       halted, illegal, flag_z, flag_n;

  logic        start2, mem_req2, mem_we2, halted2, illegal2, flag_z2, flag_n2;
  logic [7:0]  mem_addr2, L2;
  logic [11:0] mem_wdata2, mem_rdata2, I2, Acc2;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  mem  [0:31];
  logic [11:0] mem2 [0:255];
  int          ack_dly = 0;
  int          wcnt;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [7:0]  ld_data;

  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
  } txn_t;
  txn_t exp_q[$];

  machine_w_core dut (
    .CLK(CLK), .nRST(nRST), .start(start), .step(step),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halted(halted), .illegal(illegal),
    .L(L), .I(I), .Acc(Acc), .flag_z(flag_z), .flag_n(flag_n)
  );

  machine_w_core #(.WORD_WIDTH(12), .ADDRESS_WIDTH(8), .RESET_PC('h40)) dut2 (
    .CLK(CLK), .nRST(nRST), .start(start2), .step(1'b0),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .mem_ack(mem_req2), .halted(halted2), .illegal(illegal2),
    .L(L2), .I(I2), .Acc(Acc2), .flag_z(flag_z2), .flag_n(flag_n2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model with programmable wait states.
  assign mem_ack    = mem_req && (wcnt >= ack_dly);
  assign mem_rdata  = mem[mem_addr];
  assign mem_rdata2 = mem2[mem_addr2];

  always @(posedge CLK or negedge nRST)
    if (!nRST) wcnt <= 0;
    else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;

  always @(posedge CLK)
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_req && mem_we && mem_ack) mem[mem_addr] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completed handshake is matched against the scoreboard.
  always @(negedge CLK) begin
    txn_t e;
    if (nRST && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_txn: got we %0b addr %0h expected none", mem_we, mem_addr);
      end else begin
        e = exp_q.pop_front();
        check("txn_we", 32'(mem_we), 32'(e.we));
        check("txn_addr", 32'(mem_addr), 32'(e.addr));
        if (e.we) check("txn_wdata", 32'(mem_wdata), 32'(e.wdata));
      end
    end
  end

  function automatic logic [7:0] enc(input logic [2:0] op, input logic [4:0] a);
    return {op, a};
  endfunction

  task automatic push(input logic we, input logic [4:0] a, input logic [7:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    exp_q.push_back(t);
  endtask

  task automatic poke(input logic [4:0] a, input logic [7:0] d);
    @(negedge CLK);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge CLK);
    ld_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge CLK); step = 1'b1;
    @(negedge CLK); step = 1'b0;
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 500) begin
      @(negedge CLK);
      cyc++;
    end
    if (!halted) begin
      checks++;
      fails++;
      $display("FAIL halt_timeout: got running expected halted");
    end
  endtask

  initial begin
    int cyc;
    int k;
    nRST = 1'b0; start = 1'b0; step = 1'b0; start2 = 1'b0;
    ld_en = 1'b0; ld_addr = 5'd0; ld_data = 8'd0;
    mem2[8'h40] = {4'd9, 8'h00};
    repeat (2) @(negedge CLK);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_L", 32'(L), 32'd0);
    check("rst_I", 32'(I), 32'd0);
    check("rst_Acc", 32'(Acc), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_flag_z", 32'(flag_z), 32'd1);
    nRST = 1'b1;

    // POB 10; DOD 11; LAD 12; STP with zero-wait memory.
    poke(5'd0, enc(3'd3, 5'd10));
    poke(5'd1, enc(3'd1, 5'd11));
    poke(5'd2, enc(3'd4, 5'd12));
    poke(5'd3, enc(3'd0, 5'd0));
    poke(5'd10, 8'd5);
    poke(5'd11, 8'd7);
    push(1'b0, 5'd0, 8'd0);  push(1'b0, 5'd10, 8'd0);
    push(1'b0, 5'd1, 8'd0);  push(1'b0, 5'd11, 8'd0);
    push(1'b0, 5'd2, 8'd0);  push(1'b1, 5'd12, 8'd12);
    push(1'b0, 5'd3, 8'd0);
    pulse_start();
    wait_halt(cyc);
    check("t2_cycles", 32'(cyc), 32'd11);
    check("t2_m12", 32'(mem[12]), 32'd12);
    check("t2_Acc", 32'(Acc), 32'd12);
    check("t2_L", 32'(L), 32'd4);
    check("t2_illegal", 32'(illegal), 32'd0);

    // Reset while a fetch is outstanding.
    ack_dly = 3;
    pulse_start();
    check("t1_req_before", 32'(mem_req), 32'd1);
    check("t1_addr_before", 32'(mem_addr), 32'd4);
    #2 nRST = 1'b0;
    #1;
    check("t1_req_async", 32'(mem_req), 32'd0);
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_L", 32'(L), 32'd0);
    check("t1_Acc", 32'(Acc), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    ack_dly = 2;

    // Underflow, conditional jumps, single-step, start ignored while running.
    do_reset();
    poke(5'd0, enc(3'd3, 5'd13));
    poke(5'd1, enc(3'd2, 5'd14));
    poke(5'd2, enc(3'd6, 5'd20));
    poke(5'd20, enc(3'd3, 5'd15));
    poke(5'd21, enc(3'd7, 5'd7));
    poke(5'd7, enc(3'd6, 5'd9));
    poke(5'd8, enc(3'd0, 5'd0));
    poke(5'd13, 8'd3);
    poke(5'd14, 8'd5);
    poke(5'd15, 8'd0);
    push(1'b0, 5'd0, 8'd0); push(1'b0, 5'd13, 8'd0);
    pulse_step();
    pulse_start();
    wait_halt(cyc);
    repeat (3) @(negedge CLK);
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_L", 32'(L), 32'd1);
    check("t5_Acc", 32'(Acc), 32'd3);
    ack_dly = 0;
    push(1'b0, 5'd1, 8'd0); push(1'b0, 5'd14, 8'd0);
    pulse_step(); wait_halt(cyc);
    check("t3_Acc_under", 32'(Acc), 32'hFE);
    check("t3_flag_n", 32'(flag_n), 32'd1);
    check("t3_flag_z0", 32'(flag_z), 32'd0);
    push(1'b0, 5'd2, 8'd0);
    pulse_step(); wait_halt(cyc);
    check("t3_som_taken", 32'(L), 32'd20);
    push(1'b0, 5'd20, 8'd0); push(1'b0, 5'd15, 8'd0);
    pulse_step(); wait_halt(cyc);
    check("t3_Acc_zero", 32'(Acc), 32'd0);
    check("t3_flag_z", 32'(flag_z), 32'd1);
    push(1'b0, 5'd21, 8'd0);
    pulse_step(); wait_halt(cyc);
    check("t3_soz_taken", 32'(L), 32'd7);
    push(1'b0, 5'd7, 8'd0);
    pulse_step(); wait_halt(cyc);
    check("t3_som_not", 32'(L), 32'd8);
    push(1'b0, 5'd8, 8'd0);
    pulse_step(); wait_halt(cyc);
    check("t3_stp_L", 32'(L), 32'd9);
    check("t3_stp_I", 32'(I), 32'd0);

    // PC wrap at 31 with a slow memory.
    do_reset();
    poke(5'd0, enc(3'd5, 5'd31));
    poke(5'd31, enc(3'd0, 5'd0));
    ack_dly = 3;
    push(1'b0, 5'd0, 8'd0); push(1'b0, 5'd31, 8'd0);
    pulse_start();
    k = 0;
    while (!(mem_req && mem_addr == 5'd31) && k < 100) begin
      @(negedge CLK);
      k++;
    end
    for (int j = 0; j < 3; j++) begin
      check("t4_req_hold", 32'(mem_req), 32'd1);
      check("t4_addr_hold", 32'(mem_addr), 32'd31);
      check("t4_no_ack", 32'(mem_ack), 32'd0);
      check("t4_L_hold", 32'(L), 32'd31);
      @(negedge CLK);
    end
    check("t4_ack", 32'(mem_ack), 32'd1);
    wait_halt(cyc);
    check("t4_L_wrap", 32'(L), 32'd0);
    check("t4_I", 32'(I), 32'd0);
    ack_dly = 0;

    // Wide variant: reset PC 0x40 and an illegal opcode.
    check("t6_halted0", 32'(halted2), 32'd1);
    check("t6_L0", 32'(L2), 32'h40);
    check("t6_illegal0", 32'(illegal2), 32'd0);
    @(negedge CLK); start2 = 1'b1;
    @(negedge CLK); start2 = 1'b0;
    check("t6_req", 32'(mem_req2), 32'd1);
    check("t6_addr", 32'(mem_addr2), 32'h40);
    check("t6_we", 32'(mem_we2), 32'd0);
    k = 0;
    while (!halted2 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    check("t6_halted", 32'(halted2), 32'd1);
    check("t6_illegal", 32'(illegal2), 32'd1);
    check("t6_L", 32'(L2), 32'h41);
    check("t6_I", 32'(I2), 32'h900);
    check("t6_flag_z", 32'(flag_z2), 32'd1);
    check("t6_flag_n", 32'(flag_n2), 32'd0);
    check("t6_Acc", 32'(Acc2), 32'd0);
    check("t6_wdata", 32'(mem_wdata2), 32'd0);

    @(negedge CLK);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
